// File: rtl/r5fp_stimgen_pkg.sv
// Shared types and constants for the FP multiplier stimulus generator.
// Special-value table encodings are derived from the operand format.
package r5fp_stimgen_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic [2:0] {
    SP_PZERO,
    SP_NZERO,
    SP_PINF,
    SP_NINF,
    SP_QNAN,
    SP_MINSUB,
    SP_MAXNORM,
    SP_ONE
  } spec_e;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [2:0]  RND_MAX   = 3'd4;

  function automatic logic [31:0] special_val(
    input spec_e cls,
    input int    expW,
    input int    sigW
  );
    logic [31:0] expOnes;
    logic [31:0] sgn;
    logic [31:0] expField;
    logic [31:0] v;
    expOnes  = ~(32'hFFFF_FFFF << expW);
    sgn      = 32'd1 << (expW + sigW);
    expField = expOnes << sigW;
    v        = '0;
    unique case (cls)
      SP_PZERO:   v = '0;
      SP_NZERO:   v = sgn;
      SP_PINF:    v = expField;
      SP_NINF:    v = sgn | expField;
      SP_QNAN:    v = expField | (32'd1 << (sigW - 1));
      SP_MINSUB:  v = 32'd1;
      SP_MAXNORM: v = ((expOnes - 32'd1) << sigW)
                    | ((32'd1 << sigW) - 32'd1);
      SP_ONE:     v = (expOnes >> 1) << sigW;
      default:    v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/r5fp_stimgen_lfsr.sv
// 32-bit Galois LFSR with synchronous seed load and step enable.
// Cleared to zero in reset so the generator outputs read zero.
module r5fp_lfsr32
  import r5fp_stimgen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seedVal,
  input  logic        step,
  output logic [31:0] value
);

  logic [31:0] nxt;

  assign nxt = {1'b0, value[31:1]}
             ^ (value[0] ? LFSR_MASK : 32'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= seedVal;
    end else if (step) begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/r5fp_mul_stimgen.sv
// Operand stream generator for the FP multiplier self-test.
// Define R5FP_STIMGEN_SPECIAL_EN to inject special values into operand a.
module r5fp_mul_stimgen
  import r5fp_stimgen_pkg::*;
#(
  parameter int EXP_W          = 8,
  parameter int SIG_W          = 23,
  parameter int SPECIAL_PERIOD = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            seed,
  input  logic [15:0]            num_vec,
  input  logic                   rnd_sweep,
  input  logic [2:0]             rnd_first,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+SIG_W:0]   out_a,
  output logic [EXP_W+SIG_W:0]   out_b,
  output logic [2:0]             out_rnd,
  output logic [15:0]            out_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int W = EXP_W + SIG_W + 1;

  if (W > 32) begin : gWidthErr
    $error("r5fp_mul_stimgen: EXP_W+SIG_W+1 exceeds 32");
  end
  if (SPECIAL_PERIOD < 2) begin : gPeriodErr
    $error("r5fp_mul_stimgen: SPECIAL_PERIOD below 2");
  end

  state_e      state;
  logic [15:0] idx;
  logic [15:0] numVecQ;
  logic [2:0]  rnd;
  logic        sweepQ;
  logic        validQ;

  logic [31:0] lfsrA;
  logic [31:0] lfsrB;
  logic [31:0] seedA;
  logic [31:0] seedB;
  logic        load;
  logic        hs;
  logic        lastVec;
  logic [2:0]  rndNext;
  logic        unusedBits;

  // An all-zero LFSR would lock up, so both seeds avoid it.
  assign seedA = (seed == 32'd0) ? 32'd1 : seed;
  assign seedB = (~seed == 32'd0) ? 32'd1 : ~seed;

  assign load = (state == IDLE) && start
             && (num_vec != 16'd0);
  assign hs      = validQ & out_ready;
  assign lastVec = (idx == numVecQ - 16'd1);
  assign rndNext = !sweepQ ? rnd
                 : (rnd == RND_MAX) ? 3'd0
                 : rnd + 3'd1;

  r5fp_lfsr32 uLfsrA (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .seedVal (seedA),
    .step    (hs),
    .value   (lfsrA)
  );

  r5fp_lfsr32 uLfsrB (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .seedVal (seedB),
    .step    (hs),
    .value   (lfsrB)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      numVecQ <= '0;
      rnd     <= '0;
      sweepQ  <= 1'b0;
      validQ  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (num_vec != 16'd0) begin
              state   <= RUN;
              idx     <= '0;
              numVecQ <= num_vec;
              rnd     <= rnd_first;
              sweepQ  <= rnd_sweep;
              validQ  <= 1'b1;
              busy    <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            idx <= idx + 16'd1;
            rnd <= rndNext;
            if (lastVec) begin
              state  <= IDLE;
              validQ <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = validQ;
  assign out_idx   = idx;
  assign out_rnd   = rnd;
  assign out_b     = lfsrB[W-1:0];

`ifdef R5FP_STIMGEN_SPECIAL_EN
  localparam logic [15:0] SP_PER = 16'(SPECIAL_PERIOD);

  logic [2:0]  specPtr;
  logic        specHit;
  logic [31:0] specWord;

  assign specHit  = (idx % SP_PER) == (SP_PER - 16'd1);
  assign specWord = special_val(spec_e'(specPtr),
                                EXP_W, SIG_W);
  assign out_a    = specHit ? specWord[W-1:0]
                            : lfsrA[W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      specPtr <= '0;
    end else if (load) begin
      specPtr <= '0;
    end else if (hs && specHit) begin
      specPtr <= specPtr + 3'd1;
    end
  end

  assign unusedBits = ^{lfsrA, lfsrB, specWord};
`else
  assign out_a      = lfsrA[W-1:0];
  assign unusedBits = ^{lfsrA, lfsrB};
`endif

endmodule
